// File: rtl/fft_peak_detect.sv
// Peak |X|^2 bin finder over the positive-frequency half of each FFT output frame.
// Optional FFT_PEAK_SUM_EN adds out_sum, the |X|^2 total over all eligible bins.
module fft_peak_detect #(
  parameter int DW      = 29,
  parameter int PW      = 11,
  parameter int SKIP_DC = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_error,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  input  logic [PW-1:0]        in_fftpts,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PW-1:0]        out_bin,
  output logic [2*DW:0]        out_mag,
  output logic                 out_frame_err,
  output logic                 busy
`ifdef FFT_PEAK_SUM_EN
  ,
  output logic [2*DW+PW:0]     out_sum
`endif
);

  localparam int MW = 2*DW + 1;
  localparam int SW = 2*DW + PW + 1;
  localparam int IW = PW + 1;

  typedef enum logic [1:0] {IDLE, ACC, DRAIN, REPORT} state_t;

  state_t                state, state_nxt;
  logic [1:0]            drain_cnt;
  logic [IW-1:0]         bin_cnt;
  logic [PW-1:0]         n_pts;
  logic                  err;

  logic                  s1_v;
  logic signed [2*DW-1:0] s1_rr, s1_ii;
  logic [IW-1:0]         s1_bin;
  logic                  s2_v;
  logic [MW-1:0]         s2_mag;
  logic [IW-1:0]         s2_bin;
  logic [MW-1:0]         best_mag;
  logic [PW-1:0]         best_bin;
  logic [SW-1:0]         sum_acc;

  logic                  accept, take_sop, take_beat;
  logic [IW-1:0]         beat_idx, beat_cnt, half_n;
  logic [PW-1:0]         n_cur;
  logic                  len_bad, n_bad, s2_elig;

  assign in_ready  = (state == IDLE) || (state == ACC);
  assign accept    = in_valid && in_ready;
  assign take_sop  = accept && in_sop;
  assign take_beat = accept && (in_sop || (state == ACC));

  assign beat_idx = in_sop ? '0 : bin_cnt;
  assign beat_cnt = beat_idx + IW'(1);
  assign n_cur    = in_sop ? in_fftpts : n_pts;
  assign len_bad  = beat_cnt != {1'b0, n_cur};
  assign n_bad    = (in_fftpts > PW'(1 << (PW-1))) || (in_fftpts < PW'(2));

  assign half_n  = {1'b0, n_pts} >> 1;
  assign s2_elig = s2_v && (s2_bin < half_n) && ((s2_bin != '0) || (SKIP_DC == 0));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take_sop) state_nxt = in_eop ? DRAIN : ACC;
      ACC:     if (accept && in_eop) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'd1) state_nxt = REPORT;
      REPORT:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : '0;
    end
  end

  // A sop always restarts the frame: whatever is still in the pipeline
  // belongs to the abandoned frame and is dropped before it reaches compare.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_cnt  <= '0;
      n_pts    <= '0;
      err      <= 1'b0;
      s1_v     <= 1'b0;
      s1_rr    <= '0;
      s1_ii    <= '0;
      s1_bin   <= '0;
      s2_v     <= 1'b0;
      s2_mag   <= '0;
      s2_bin   <= '0;
      best_mag <= '0;
      best_bin <= '0;
      sum_acc  <= '0;
    end else begin
      s1_v <= take_beat;
      if (take_beat) begin
        s1_rr   <= in_real * in_real;
        s1_ii   <= in_imag * in_imag;
        s1_bin  <= beat_idx;
        bin_cnt <= (beat_idx == '1) ? beat_idx : beat_cnt;
      end
      s2_v   <= s1_v && !take_sop;
      s2_mag <= {1'b0, s1_rr} + {1'b0, s1_ii};
      s2_bin <= s1_bin;

      if (take_sop) begin
        n_pts    <= in_fftpts;
        best_mag <= '0;
        best_bin <= '0;
        sum_acc  <= '0;
        err      <= (state == ACC) || (in_error != 2'b00) || n_bad || (in_eop && len_bad);
      end else begin
        if (s2_elig && (s2_mag > best_mag)) begin
          best_mag <= s2_mag;
          best_bin <= s2_bin[PW-1:0];
        end
        if (s2_elig) sum_acc <= sum_acc + SW'(s2_mag);
        if (take_beat) err <= err || (in_error != 2'b00) || (in_eop && len_bad);
      end
    end
  end

  assign out_valid     = (state == REPORT);
  assign out_bin       = best_bin;
  assign out_mag       = best_mag;
  assign out_frame_err = err;
  assign busy          = (state != IDLE);

`ifdef FFT_PEAK_SUM_EN
  assign out_sum = sum_acc;
`else
  logic unused_sum;
  assign unused_sum = ^sum_acc;
`endif

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: a reference peak model pushes expected
// reports per frame; a monitor pops and compares on each result handshake.
module tb_fft_peak_detect;
  localparam int DW = 29;
  localparam int PW = 11;
  localparam int MW = 2*DW + 1;
  localparam int SW = 2*DW + PW + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic          in_ready;
  logic [1:0]    in_error = 2'b00;
  logic [DW-1:0] in_real = '0, in_imag = '0;
  logic [PW-1:0] in_fftpts = '0;
  logic          out_valid, out_frame_err, busy;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_bin;
  logic [MW-1:0] out_mag;
`ifdef FFT_PEAK_SUM_EN
  logic [SW-1:0] out_sum;
`endif

  fft_peak_detect #(.DW(DW), .PW(PW), .SKIP_DC(1)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_error(in_error), .in_sop(in_sop), .in_eop(in_eop), .in_real(in_real),
    .in_imag(in_imag), .in_fftpts(in_fftpts), .out_valid(out_valid),
    .out_ready(out_ready), .out_bin(out_bin), .out_mag(out_mag),
    .out_frame_err(out_frame_err), .busy(busy)
`ifdef FFT_PEAK_SUM_EN
    , .out_sum(out_sum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] bin;
    logic [MW-1:0] mag;
    logic          err;
    logic [SW-1:0] sum;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails = 0;
  int   reports = 0;
  int   pushed = 0;
  int   re_a[64];
  int   im_a[64];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      reports++;
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_report: got bin=%0d mag=%0d, expected no report", out_bin, out_mag);
      end else begin
        e = sb.pop_front();
        if (out_bin !== e.bin) begin
          fails++;
          $display("FAIL out_bin: got %0d expected %0d", out_bin, e.bin);
        end
        checks++;
        if (out_mag !== e.mag) begin
          fails++;
          $display("FAIL out_mag: got %0d expected %0d", out_mag, e.mag);
        end
        checks++;
        if (out_frame_err !== e.err) begin
          fails++;
          $display("FAIL out_frame_err: got %0b expected %0b", out_frame_err, e.err);
        end
`ifdef FFT_PEAK_SUM_EN
        checks++;
        if (out_sum !== e.sum) begin
          fails++;
          $display("FAIL out_sum: got %0d expected %0d", out_sum, e.sum);
        end
`endif
      end
    end
  end

  task automatic clear_frame();
    for (int i = 0; i < 64; i++) begin
      re_a[i] = 0;
      im_a[i] = 0;
    end
  endtask

  // Drives one frame from re_a/im_a back to back; the reference model runs alongside.
  task automatic send_frame(input int n, input int nbeats, input bit has_eop,
                            input int err_beat, input logic [1:0] err_val, input bit pre_err);
    exp_t e;
    logic [MW-1:0] m;
    int rv, iv;
    e.bin = '0;
    e.mag = '0;
    e.sum = '0;
    e.err = pre_err || (nbeats != n) || (n > 1024) || (n < 2) ||
            ((err_beat >= 0) && (err_beat < nbeats) && (err_val != 2'b00));
    for (int b = 0; b < nbeats; b++) begin
      rv = re_a[b];
      iv = im_a[b];
      in_valid  = 1'b1;
      in_sop    = (b == 0);
      in_eop    = has_eop && (b == nbeats - 1);
      in_real   = rv[DW-1:0];
      in_imag   = iv[DW-1:0];
      in_error  = (b == err_beat) ? err_val : 2'b00;
      in_fftpts = PW'(n);
      if ((b < n / 2) && (b != 0)) begin
        m = MW'(longint'(rv) * longint'(rv) + longint'(iv) * longint'(iv));
        if (m > e.mag) begin
          e.mag = m;
          e.bin = PW'(b);
        end
        e.sum = e.sum + SW'(m);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_error = 2'b00;
    if (has_eop) begin
      sb.push_back(e);
      pushed++;
    end
  endtask

  // Returns cycles from the eop edge until out_valid (or -1 if it never comes).
  task automatic wait_report(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic ack();
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++;
    if ({out_bin, out_mag, out_frame_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got bin=%0d mag=%0d err=%0b expected all 0", out_bin, out_mag, out_frame_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_single_peak();
    int lat;
    clear_frame();
    re_a[3] = 1000;
    send_frame(16, 16, 1, -1, 2'b00, 1'b0);
    wait_report(lat);
    checks++;
    if (lat !== 3) begin fails++; $display("FAIL peak_latency: got %0d expected 3", lat); end
    checks++;
    if ({in_ready, busy} !== 2'b01) begin
      fails++;
      $display("FAIL report_ready_busy: got in_ready=%0b busy=%0b expected 0/1", in_ready, busy);
    end
    if (lat > 0) ack();
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL post_ack_idle: got out_valid=%0b in_ready=%0b expected 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_tie_dc();
    int lat;
    clear_frame();
    re_a[0]  = 5000;
    im_a[5]  = -700;
    im_a[6]  = -700;
    re_a[12] = 9999;
    send_frame(16, 16, 1, -1, 2'b00, 1'b0);
    wait_report(lat);
    checks++;
    if (lat !== 3) begin fails++; $display("FAIL tie_latency: got %0d expected 3", lat); end
    if (lat > 0) ack();
  endtask

  task automatic test_extreme();
    int lat;
    clear_frame();
    re_a[2] = -(1 << 28);
    im_a[2] = -(1 << 28);
    send_frame(8, 8, 1, -1, 2'b00, 1'b0);
    wait_report(lat);
    checks++;
    if (out_mag !== (MW'(1) << 57)) begin fails++; $display("FAIL extreme_mag: got %0d expected 2^57", out_mag); end
    if (lat > 0) ack();
  endtask

  task automatic test_errors();
    int lat;
    clear_frame();
    re_a[2] = 50;
    send_frame(16, 10, 1, -1, 2'b00, 1'b0);
    wait_report(lat);
    checks++;
    if (lat !== 3) begin fails++; $display("FAIL short_latency: got %0d expected 3", lat); end
    if (lat > 0) ack();
    clear_frame();
    re_a[4] = 77;
    im_a[4] = 11;
    send_frame(16, 16, 1, 4, 2'b01, 1'b0);
    wait_report(lat);
    if (lat > 0) ack();
    send_frame(1, 1, 1, -1, 2'b00, 1'b0);
    wait_report(lat);
    checks++;
    if (lat !== 3) begin fails++; $display("FAIL sop_eop_latency: got %0d expected 3", lat); end
    if (lat > 0) ack();
  endtask

  task automatic test_mid_sop();
    int lat;
    clear_frame();
    re_a[3] = 30000;
    re_a[4] = 30000;
    send_frame(16, 5, 0, -1, 2'b00, 1'b0);
    clear_frame();
    re_a[5] = 123;
    send_frame(16, 16, 1, -1, 2'b00, 1'b1);
    wait_report(lat);
    checks++;
    if (lat !== 3) begin fails++; $display("FAIL mid_sop_latency: got %0d expected 3", lat); end
    if (lat > 0) ack();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [PW-1:0] bin0;
    logic [MW-1:0] mag0;
    clear_frame();
    re_a[7] = -300;
    im_a[7] = 400;
    send_frame(16, 16, 1, -1, 2'b00, 1'b0);
    wait_report(lat);
    bin0 = 7;
    mag0 = 250000;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready} !== 2'b10 || out_bin !== bin0 || out_mag !== mag0) begin
        fails++;
        $display("FAIL hold_stable cycle %0d: got valid=%0b ready=%0b bin=%0d mag=%0d expected 1/0/%0d/%0d",
                 c, out_valid, in_ready, out_bin, out_mag, bin0, mag0);
      end
    end
    ack();
    checks++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready: got %0b expected 1", in_ready); end
    clear_frame();
    re_a[1] = 77;
    send_frame(8, 8, 1, -1, 2'b00, 1'b0);
    wait_report(lat);
    checks++;
    if (lat !== 3) begin fails++; $display("FAIL b2b_latency: got %0d expected 3", lat); end
    if (lat > 0) ack();
  endtask

  task automatic test_reset_mid();
    int lat;
    clear_frame();
    re_a[4] = 500;
    send_frame(16, 7, 0, -1, 2'b00, 1'b0);
    in_valid = 1'b1;
    reset_n  = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset_n  = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      fails++;
      $display("FAIL reset_mid: got valid=%0b ready=%0b busy=%0b expected 0/1/0", out_valid, in_ready, busy);
    end
    @(posedge clk); #1;
    for (int b = 0; b < 5; b++) begin
      in_valid = 1'b1;
      in_real  = DW'(20000);
      in_eop   = (b == 4);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_eop   = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL stray_dropped: got busy=%0b expected 0", busy); end
    @(posedge clk); #1;
    clear_frame();
    re_a[6] = 321;
    send_frame(16, 16, 1, -1, 2'b00, 1'b0);
    wait_report(lat);
    checks++;
    if (lat !== 3) begin fails++; $display("FAIL post_reset_latency: got %0d expected 3", lat); end
    if (lat > 0) ack();
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_tie_dc();
    test_extreme();
    test_errors();
    test_mid_sop();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(posedge clk);
    checks++;
    if (reports !== pushed || sb.size() != 0) begin
      fails++;
      $display("FAIL report_count: got %0d reports (%0d pending) expected %0d", reports, sb.size(), pushed);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
